// File: rtl/max_pool_pkg.sv
// Shared types and geometry helpers for the max-pooling controller, datapath and bench.
package max_pool_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DEF_ROW_SIZE   = 540;
  localparam int DEF_NUM_ROWS   = 540;
  localparam int DEF_KERNEL_DIM = 3;
  localparam int COL_W = $clog2(DEF_ROW_SIZE);
  localparam int ROW_W = $clog2(DEF_NUM_ROWS);
  localparam int PTR_W = $clog2(DEF_KERNEL_DIM);

  // Trailing positions that cannot fill a whole window are dropped (floor).
  function automatic int win_per_line(input int size, input int k, input int s);
    return (size - k) / s + 1;
  endfunction

  function automatic int win_per_frame(input int cols, input int rows, input int k, input int s);
    return win_per_line(cols, k, s) * win_per_line(rows, k, s);
  endfunction

  function automatic int last_aligned(input int size, input int k, input int s);
    return (k - 1) + (win_per_line(size, k, s) - 1) * s;
  endfunction

endpackage

// File: rtl/max_pool_stride_cnt.sv
// Wrapping position counter with stride phase; flags window-aligned and last-aligned positions.
// Phase restarts at K-1 and after every wrap, so alignment needs no divider.
module max_pool_stride_cnt
  import max_pool_pkg::*;
#(
  parameter int SIZE   = 540,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int W      = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] pos_o,
  output logic         wrap_o,
  output logic         aligned_o,
  output logic         last_al_o
);

  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [W-1:0]    POS_MAX = W'(SIZE - 1);
  localparam logic [W-1:0]    KM1     = W'(K - 1);
  localparam logic [W-1:0]    LAST_AL = W'(last_aligned(SIZE, K, STRIDE));
  localparam logic [PH_W-1:0] PH_MAX  = PH_W'(STRIDE - 1);

  logic [W-1:0]    pos_q, pos_d;
  logic [PH_W-1:0] ph_q, ph_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      ph_q  <= '0;
    end else begin
      pos_q <= pos_d;
      ph_q  <= ph_d;
    end
  end

  always_comb begin
    pos_d = pos_q;
    ph_d  = ph_q;
    if (clr_i) begin
      pos_d = '0;
      ph_d  = '0;
    end else if (en_i) begin
      if (pos_q == POS_MAX) begin
        pos_d = '0;
        ph_d  = '0;
      end else begin
        pos_d = pos_q + 1'b1;
        if (pos_q >= KM1) ph_d = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
      end
    end
  end

  assign pos_o     = pos_q;
  assign wrap_o    = (pos_q == POS_MAX);
  assign aligned_o = (pos_q >= KM1) && (ph_q == '0);
  assign last_al_o = (pos_q == LAST_AL);

endmodule

// File: rtl/max_pool_ctrl.sv
// Raster/window sequencer for the max-pool datapath; tracks a POOL_LAT-deep valid pipe and stalls on out_ready.
// Optional MAX_POOL_CTRL_STATS_EN adds saturating stall_cycles / windows_out counters.
module max_pool_ctrl
  import max_pool_pkg::*;
#(
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 2,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int POOL_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          lb_wr_en,
  output logic [$clog2(ROW_SIZE)-1:0]   lb_wr_addr,
  output logic [$clog2(KERNEL_DIM)-1:0] lb_wr_row,
  output logic                          win_shift,
  output logic                          win_valid,
  output logic                          pipe_en,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          frame_done
`ifdef MAX_POOL_CTRL_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   windows_out
`endif
);

  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int PW = $clog2(KERNEL_DIM);

  state_e            state_q, state_d;
  logic              clr, hold, accept, run_st;
  logic              col_wrap, col_al, col_la, row_wrap, row_al, row_la;
  logic              win_last;
  logic [CW-1:0]     col_pos;
  logic [RW-1:0]     row_pos;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [POOL_LAT-1:0] vld_q, vld_d, lst_q, lst_d;

  assign clr     = (state_q == IDLE) && start;
  assign hold    = vld_q[POOL_LAT-1] && !out_ready;
  assign pipe_en = busy && !hold;
  assign in_ready = run_st && !hold;
  assign accept  = in_valid && in_ready;

  max_pool_stride_cnt #(.SIZE(ROW_SIZE), .K(KERNEL_DIM), .STRIDE(STRIDE), .W(CW)) u_col (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(accept),
    .pos_o(col_pos), .wrap_o(col_wrap), .aligned_o(col_al), .last_al_o(col_la)
  );

  max_pool_stride_cnt #(.SIZE(NUM_ROWS), .K(KERNEL_DIM), .STRIDE(STRIDE), .W(RW)) u_row (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(accept && col_wrap),
    .pos_o(row_pos), .wrap_o(row_wrap), .aligned_o(row_al), .last_al_o(row_la)
  );

  assign win_valid = accept && col_al && row_al;
  assign win_last  = win_valid && col_la && row_la;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) ptr_d = '0;
    else if (accept && col_wrap) ptr_d = (ptr_q == PW'(KERNEL_DIM - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Index 0 takes the launch; index POOL_LAT-1 is the datapath output stage.
  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    if (pipe_en) begin
      vld_d[0] = win_valid;
      lst_d[0] = win_last;
      for (int i = 1; i < POOL_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        lst_d[i] = lst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && col_wrap && row_wrap) state_d = DRAIN;
      DRAIN:   if (vld_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    run_st     = (state_q == RUN);
    frame_done = (state_q == DONE);
  end

  assign lb_wr_en   = accept;
  assign win_shift  = accept;
  assign lb_wr_addr = col_pos;
  assign lb_wr_row  = ptr_q;
  assign out_valid  = vld_q[POOL_LAT-1];
  assign out_last   = vld_q[POOL_LAT-1] && lst_q[POOL_LAT-1];

`ifdef MAX_POOL_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d, wout_q, wout_d;

  always_comb begin
    stall_d = stall_q;
    wout_d  = wout_q;
    if (clr) begin
      stall_d = '0;
      wout_d  = '0;
    end else begin
      if (run_st && in_valid && !in_ready && stall_q != '1) stall_d = stall_q + 1'b1;
      if (out_valid && out_ready && wout_q != '1) wout_d = wout_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      wout_q  <= '0;
    end else begin
      stall_q <= stall_d;
      wout_q  <= wout_d;
    end
  end

  assign stall_cycles = stall_q;
  assign windows_out  = wout_q;
`endif

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed bench: DUT A is 8x6/K3/S2, DUT B is 5x3/K3/S1; sel picks which one the frame runner drives.
module tb_max_pool_ctrl;

  logic clk = 1'b0;
  logic rst_n, sel, start, in_valid, out_ready;
  always #5 clk = ~clk;

  logic a_in_ready, a_lb_wr_en, a_win_shift, a_win_valid, a_pipe_en, a_out_valid, a_out_last, a_busy, a_frame_done;
  logic b_in_ready, b_lb_wr_en, b_win_shift, b_win_valid, b_pipe_en, b_out_valid, b_out_last, b_busy, b_frame_done;
  logic [2:0] a_addr, b_addr;
  logic [1:0] a_row, b_row;
  logic [31:0] a_stall, a_wout, b_stall, b_wout;

  max_pool_ctrl #(.KERNEL_DIM(3), .STRIDE(2), .ROW_SIZE(8), .NUM_ROWS(6), .POOL_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .lb_wr_en(a_lb_wr_en), .lb_wr_addr(a_addr), .lb_wr_row(a_row), .win_shift(a_win_shift),
    .win_valid(a_win_valid), .pipe_en(a_pipe_en), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(out_ready), .busy(a_busy), .frame_done(a_frame_done)
`ifdef MAX_POOL_CTRL_STATS_EN
    , .stall_cycles(a_stall), .windows_out(a_wout)
`endif
  );

  max_pool_ctrl #(.KERNEL_DIM(3), .STRIDE(1), .ROW_SIZE(5), .NUM_ROWS(3), .POOL_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .lb_wr_en(b_lb_wr_en), .lb_wr_addr(b_addr), .lb_wr_row(b_row), .win_shift(b_win_shift),
    .win_valid(b_win_valid), .pipe_en(b_pipe_en), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(out_ready), .busy(b_busy), .frame_done(b_frame_done)
`ifdef MAX_POOL_CTRL_STATS_EN
    , .stall_cycles(b_stall), .windows_out(b_wout)
`endif
  );

`ifdef MAX_POOL_CTRL_STATS_EN
`else
  assign a_stall = '0;
  assign a_wout  = '0;
  assign b_stall = '0;
  assign b_wout  = '0;
`endif

  logic m_in_ready, m_lb_wr_en, m_win_shift, m_win_valid, m_pipe_en, m_out_valid, m_out_last, m_busy, m_frame_done;
  logic [2:0] m_addr;
  logic [1:0] m_row;
  logic [31:0] m_stall, m_wout;
  assign m_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign m_lb_wr_en   = sel ? b_lb_wr_en   : a_lb_wr_en;
  assign m_win_shift  = sel ? b_win_shift  : a_win_shift;
  assign m_win_valid  = sel ? b_win_valid  : a_win_valid;
  assign m_pipe_en    = sel ? b_pipe_en    : a_pipe_en;
  assign m_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign m_out_last   = sel ? b_out_last   : a_out_last;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_addr       = sel ? b_addr       : a_addr;
  assign m_row        = sel ? b_row        : a_row;
  assign m_stall      = sel ? b_stall      : a_stall;
  assign m_wout       = sel ? b_wout       : a_wout;

  typedef struct {
    int cfg;
    int r;
    int c;
  } win_t;

  win_t exp_win[9];
  int   tests = 0;
  int   fails = 0;
  int   obs_r[$];
  int   obs_c[$];
  bit   res_last[$];
  int   n_acc, seq_err, stall_seen, fd_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {19'd0, m_busy, m_in_ready, m_lb_wr_en, m_win_shift, m_win_valid, m_pipe_en,
            m_out_valid, m_out_last, m_frame_done, m_addr, m_row};
  endfunction

  // mode 0: continuous; 1: 5-cycle out_ready stall at first result; 2: random in_valid + stray starts; 3: abort at (3,5)
  task automatic run_frame(input int mode, input int ncol, input int nrow, input int k);
    int  r, c, total, stall_left;
    bit  drain_pulse, done, first;
    obs_r.delete(); obs_c.delete(); res_last.delete();
    n_acc = 0; seq_err = 0; stall_seen = 0; fd_cnt = 0;
    r = 0; c = 0; total = ncol * nrow; stall_left = 0;
    drain_pulse = 0; done = 0; first = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (mode == 3 && n_acc == 29) begin
        check("pre_abort_addr", 32'(m_addr), 32'd5);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs_zero", out_vec(), 32'd0);
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (m_frame_done) fd_cnt++;
        end
        check("abort_no_frame_done", fd_cnt, 0);
        rst_n = 1'b1;
        return;
      end
      start = (cyc == 0) || drain_pulse ||
              (mode == 2 && cyc > 0 && n_acc < total && $urandom_range(3) == 0);
      drain_pulse = 0;
      in_valid  = (n_acc < total) && (mode != 2 || $urandom_range(1) == 1);
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      if (in_valid && m_in_ready) begin
        if (!m_lb_wr_en || !m_win_shift || m_addr != 3'(c) || m_row != 2'(r % k)) seq_err++;
        if (m_win_valid) begin
          obs_r.push_back(r);
          obs_c.push_back(c);
          if (mode == 1 && !first) begin
            stall_left = 5;
            first = 1;
          end
        end
        n_acc++;
        if (c == ncol - 1) begin c = 0; r++; end
        else c++;
        if (mode == 2 && n_acc == total) drain_pulse = 1;
      end else if (m_lb_wr_en || m_win_shift || m_win_valid) begin
        seq_err++;
      end
      if (m_out_valid && out_ready) res_last.push_back(m_out_last);
      if (m_out_valid && !out_ready) begin
        stall_seen++;
        if (m_in_ready) seq_err++;
      end
      if (m_frame_done) begin
        fd_cnt++;
        done = 1;
      end
    end
    check("frame_finished", 32'(done), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("idle_after_frame", {30'd0, m_busy, m_frame_done}, 32'd0);
  endtask

  task automatic verify(input string tag, input int cfg, input int total, input int nwin);
    int j, nl;
    check({tag, "_accepts"}, n_acc, total);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_win_count"}, obs_r.size(), nwin);
    j = 0;
    for (int i = 0; i < 9; i++) begin
      if (exp_win[i].cfg == cfg) begin
        if (j < obs_r.size())
          check($sformatf("%s_win%0d_rc", tag, j), obs_r[j] * 100 + obs_c[j], exp_win[i].r * 100 + exp_win[i].c);
        j++;
      end
    end
    check({tag, "_results"}, res_last.size(), nwin);
    nl = 0;
    foreach (res_last[i]) nl += int'(res_last[i]);
    check({tag, "_last_count"}, nl, 1);
    if (res_last.size() > 0) check({tag, "_last_on_final"}, 32'(res_last[res_last.size()-1]), 32'd1);
    check({tag, "_frame_done"}, fd_cnt, 1);
  endtask

  initial begin
    exp_win[0] = '{0, 2, 2}; exp_win[1] = '{0, 2, 4}; exp_win[2] = '{0, 2, 6};
    exp_win[3] = '{0, 4, 2}; exp_win[4] = '{0, 4, 4}; exp_win[5] = '{0, 4, 6};
    exp_win[6] = '{1, 2, 2}; exp_win[7] = '{1, 2, 3}; exp_win[8] = '{1, 2, 4};

    rst_n = 1'b0; sel = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_outputs_zero", out_vec(), 32'd0);
    rst_n = 1'b1;

    run_frame(0, 8, 6, 3);
    verify("t1", 0, 48, 6);

    run_frame(1, 8, 6, 3);
    verify("t2", 0, 48, 6);
    check("t2_stall_held", stall_seen, 5);
`ifdef MAX_POOL_CTRL_STATS_EN
    check("t6_stall_cycles", m_stall, 32'd5);
    check("t6_windows_out", m_wout, 32'd6);
`endif

    sel = 1'b1;
    run_frame(0, 5, 3, 3);
    verify("t3", 1, 15, 3);
    sel = 1'b0;

    run_frame(3, 8, 6, 3);
    run_frame(0, 8, 6, 3);
    verify("t4", 0, 48, 6);

    run_frame(2, 8, 6, 3);
    verify("t5", 0, 48, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
